// File: rtl/band_mixer.sv
// Band mixer: multiplies each carrier band by its envelope with one shared multiplier
// and sums the bands into a saturated 32-bit sample. Define BAND_GAIN_EN for per-band Q1.15 gain.
module band_mixer #(
    parameter int N_FILTERS = 8,
    parameter int FRAC_BITS = 24
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               valid_in,
    input  logic signed [31:0] carrier_in  [N_FILTERS],
    input  logic signed [31:0] envelope_in [N_FILTERS],
`ifdef BAND_GAIN_EN
    input  logic        [15:0] band_gain_in [N_FILTERS],
`endif
    output logic signed [31:0] sample_out,
    output logic               valid_out,
    output logic               busy_out,
    output logic               overrun_out
);

    localparam int IDX_W = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FILTERS - 1);
    localparam logic signed [63:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t             state;
    logic signed [31:0] snap_c [N_FILTERS];
    logic signed [31:0] snap_e [N_FILTERS];
`ifdef BAND_GAIN_EN
    logic        [15:0] snap_g [N_FILTERS];
    logic signed [63:0] g_ext;
`endif
    logic [IDX_W-1:0]   idx;
    logic signed [63:0] acc;
    logic signed [63:0] c_ext;
    logic signed [63:0] e_ext;
    logic signed [63:0] term;
    logic signed [31:0] sat_val;

    // One band term per cycle from the shared multiplier; >>> floors toward -inf.
    always_comb begin
        c_ext = snap_c[idx];
        e_ext = snap_e[idx];
        term  = (c_ext * e_ext) >>> FRAC_BITS;
`ifdef BAND_GAIN_EN
        g_ext = {48'd0, snap_g[idx]};
        term  = (term * g_ext) >>> 15;
`endif
    end

    always_comb begin
        if (acc > SAT_MAX) begin
            sat_val = 32'h7FFF_FFFF;
        end else if (acc < SAT_MIN) begin
            sat_val = 32'h8000_0000;
        end else begin
            sat_val = acc[31:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            sample_out  <= '0;
            valid_out   <= 1'b0;
            busy_out    <= 1'b0;
            overrun_out <= 1'b0;
            for (int i = 0; i < N_FILTERS; i++) begin
                snap_c[i] <= '0;
                snap_e[i] <= '0;
`ifdef BAND_GAIN_EN
                snap_g[i] <= '0;
`endif
            end
        end else begin
            valid_out   <= 1'b0;
            // busy_out is still high during OUT, so a frame arriving then is dropped too.
            overrun_out <= valid_in && busy_out;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        for (int i = 0; i < N_FILTERS; i++) begin
                            snap_c[i] <= carrier_in[i];
                            snap_e[i] <= envelope_in[i];
`ifdef BAND_GAIN_EN
                            snap_g[i] <= band_gain_in[i];
`endif
                        end
                        acc      <= '0;
                        idx      <= '0;
                        busy_out <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + term;
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    sample_out <= sat_val;
                    valid_out  <= 1'b1;
                    busy_out   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_band_mixer.sv
// Testbench for band_mixer: directed frames from fixed expected values plus random frames
// scored against an arithmetic model of the band mix (floor division, explicit saturation).
module tb_band_mixer;

    localparam int N    = 8;
    localparam int FRAC = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_in;
    logic signed [31:0] drv_c [N];
    logic signed [31:0] drv_e [N];
`ifdef BAND_GAIN_EN
    logic        [15:0] drv_g [N];
`endif
    logic [31:0]        sample_out;
    logic               valid_out;
    logic               busy_out;
    logic               overrun_out;

    int          total    = 0;
    int          bad      = 0;
    int          vo_count = 0;
    int          ov_count = 0;
    logic [31:0] exp_q[$];

    band_mixer #(.N_FILTERS(N), .FRAC_BITS(FRAC)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .valid_in    (valid_in),
        .carrier_in  (drv_c),
        .envelope_in (drv_e),
`ifdef BAND_GAIN_EN
        .band_gain_in(drv_g),
`endif
        .sample_out  (sample_out),
        .valid_out   (valid_out),
        .busy_out    (busy_out),
        .overrun_out (overrun_out)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    function automatic longint floor_div(input longint a, input longint d);
        longint q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int gain_of(input int b);
`ifdef BAND_GAIN_EN
        return int'(drv_g[b]);
`else
        return 32768 + 0 * b;
`endif
    endfunction

    function automatic logic [31:0] mix_model();
        longint sum   = 0;
        longint scale = longint'(1) << FRAC;
        for (int b = 0; b < N; b++) begin
            longint p = longint'(drv_c[b]) * longint'(drv_e[b]);
            longint t = floor_div(p, scale);
            t   = floor_div(t * longint'(gain_of(b)), 32768);
            sum = sum + t;
        end
        if (sum > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (sum < -64'sd2147483648) return 32'h8000_0000;
        return 32'(sum);
    endfunction

    // Scoreboard: every valid_out pulse consumes one expected sample
    always @(negedge clk) begin
        if (valid_out) begin
            vo_count++;
            if (exp_q.size() == 0) check("sb_q", 64'(exp_q.size()), 64'd1);
            else check("sb_sample", 64'(sample_out), 64'(exp_q.pop_front()));
        end
        if (overrun_out) ov_count++;
    end

    // Driver tasks
    task automatic set_all(input logic [31:0] c, input logic [31:0] e);
        for (int b = 0; b < N; b++) begin
            drv_c[b] = c;
            drv_e[b] = e;
`ifdef BAND_GAIN_EN
            drv_g[b] = 16'h8000;
`endif
        end
    endtask

    task automatic set_random();
        int mode = $urandom_range(0, 2);
        for (int b = 0; b < N; b++) begin
            case (mode)
                0: begin
                    drv_c[b] = $urandom;
                    drv_e[b] = $urandom;
                end
                1: begin
                    drv_c[b] = 32'($urandom_range(0, 32'h03FF_FFFF)) - 32'h0200_0000;
                    drv_e[b] = 32'($urandom_range(0, 32'h03FF_FFFF)) - 32'h0200_0000;
                end
                default: begin
                    drv_c[b] = $urandom;
                    drv_e[b] = 32'($urandom_range(0, 32'h01FF_FFFF)) - 32'h0100_0000;
                end
            endcase
`ifdef BAND_GAIN_EN
            drv_g[b] = 16'($urandom_range(0, 16'hFFFF));
`endif
        end
    endtask

    task automatic send();
        @(negedge clk);
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        while (1) begin
            @(posedge clk);
            #1 cycles++;
            if (valid_out) break;
            if (cycles >= budget) begin
                cycles = -1;
                break;
            end
        end
    endtask

    task automatic run_frame(input logic [31:0] exp, input string tag);
        int cyc;
        exp_q.push_back(exp);
        send();
        check({tag, "_busy"}, 64'(busy_out), 64'd1);
        wait_valid(2 * N + 10, cyc);
        check({tag, "_lat"}, 64'(cyc), 64'(N + 1));
        check({tag, "_sample"}, 64'(sample_out), 64'(exp));
        @(posedge clk);
        #1 check({tag, "_vo_pulse"}, 64'(valid_out), 64'd0);
        check({tag, "_idle"}, 64'(busy_out), 64'd0);
    endtask

    logic [31:0] dir_c [5] = '{32'h0100_0000, 32'hFF00_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] dir_e [5] = '{32'h0100_0000, 32'h0080_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] dir_x [5] = '{32'h0800_0000, 32'hFC00_0000, 32'hFFFF_FFF8, 32'h7FFF_FFFF, 32'h8000_0000};
    string       dir_n [5] = '{"unity", "neg", "floor", "sat_max", "sat_min"};

    initial begin
        int cyc;
        int vo0;
        int ov0;
        rst      = 1'b1;
        valid_in = 1'b0;
        set_all(32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_sample", 64'(sample_out), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_overrun", 64'(overrun_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            set_all(dir_c[i], dir_e[i]);
            run_frame(dir_x[i], dir_n[i]);
            repeat (3) @(posedge clk);
            #1 check({dir_n[i], "_hold"}, 64'(sample_out), 64'(dir_x[i]));
        end

        // Overrun: a second frame 3 cycles after the first is dropped
        vo0 = vo_count;
        ov0 = ov_count;
        set_all(32'h0100_0000, 32'h0100_0000);
        exp_q.push_back(32'h0800_0000);
        send();
        set_all(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        repeat (2) @(posedge clk);
        send();
        wait_valid(2 * N + 10, cyc);
        check("ovr_lat", 64'(cyc), 64'(N + 1 - 3));
        check("ovr_sample", 64'(sample_out), 64'h0800_0000);
        repeat (2 * N + 4) @(posedge clk);
        #1;
        check("ovr_pulses", 64'(ov_count - ov0), 64'd1);
        check("ovr_valids", 64'(vo_count - vo0), 64'd1);

        // Back-to-back: a frame issued in the valid_out cycle is accepted
        ov0 = ov_count;
        set_all(32'h0100_0000, 32'h0100_0000);
        exp_q.push_back(32'h0800_0000);
        send();
        wait_valid(2 * N + 10, cyc);
        check("b2b_first_lat", 64'(cyc), 64'(N + 1));
        set_all(32'hFF00_0000, 32'h0080_0000);
        exp_q.push_back(32'hFC00_0000);
        send();
        wait_valid(2 * N + 10, cyc);
        check("b2b_gap", 64'(cyc + 1), 64'(N + 2));
        check("b2b_sample", 64'(sample_out), 64'hFC00_0000);
        check("b2b_no_overrun", 64'(ov_count - ov0), 64'd0);
        repeat (2) @(posedge clk);

        // Reset in the middle of MAC abandons the frame
        vo0 = vo_count;
        set_all(32'h0200_0000, 32'h0100_0000);
        send();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_sample", 64'(sample_out), 64'd0);
        check("mid_rst_busy", 64'(busy_out), 64'd0);
        check("mid_rst_valid", 64'(valid_out), 64'd0);
        check("mid_rst_overrun", 64'(overrun_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * N + 4) @(posedge clk);
        #1 check("mid_rst_no_valid", 64'(vo_count - vo0), 64'd0);
        set_all(32'h0100_0000, 32'h0100_0000);
        run_frame(32'h0800_0000, "after_rst");

`ifdef BAND_GAIN_EN
        set_all(32'h0100_0000, 32'h0100_0000);
        drv_g[0] = 16'h4000;
        run_frame(32'h0780_0000, "gain_half0");
        for (int b = 0; b < N; b++) drv_g[b] = 16'h0000;
        run_frame(32'h0000_0000, "gain_zero");
`endif

        // Random frames against the model
        for (int k = 0; k < 30; k++) begin
            set_random();
            run_frame(mix_model(), "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        #1 check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/band_mixer.md
Name: band_mixer

Overview:
- Synthesis end of the vocoder. Consumes one frame of per-band filtered carrier and envelope values from the filterbank (one frame per audio sample).
- Multiplies each carrier band by its envelope and sums all bands into one saturated 32-bit output sample.
- Uses a single time-multiplexed multiplier, one band per cycle, to conserve DSP slices. Sits between the filterbank and the audio output path.

Parameters:
- N_FILTERS, 8, number of bands per frame; must match the filterbank.
- FRAC_BITS, 24, fractional bits of the envelope value; each product is arithmetically shifted right by this amount.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- valid_in  input  1  one-cycle pulse; frame present on carrier_in/envelope_in
- carrier_in  input  signed 32 x N_FILTERS  per-band filtered carrier
- envelope_in  input  signed 32 x N_FILTERS  per-band envelope
- sample_out  output  signed 32  mixed output sample
- valid_out  output  1  one-cycle pulse; sample_out updated
- busy_out  output  1  high while a frame is being processed
- overrun_out  output  1  one-cycle pulse; valid_in arrived while busy and was dropped

Behaviour:
- Reset (asynchronous, rst_in=1):
  - sample_out=0, valid_out=0, busy_out=0, overrun_out=0.
  - State to IDLE; accumulator, band index and snapshot cleared.
  - Reset mid-frame abandons the frame; no valid_out is produced for it.
- States: IDLE, MAC, OUT.
- IDLE:
  - On valid_in, snapshot all carrier_in/envelope_in into internal registers.
  - Clear accumulator, set index=0, set busy_out=1, go to MAC.
  - Inputs may change freely after the capture edge.
- MAC: each cycle does acc += (snap_c[idx]*snap_e[idx]) >>> FRAC_BITS.
  - Full 64-bit signed product; arithmetic shift, which floors toward -inf.
  - 64-bit signed accumulator; no wrap is possible for N_FILTERS<=256.
  - Increment idx; after idx=N_FILTERS-1 is accumulated, go to OUT.
- OUT:
  - sample_out <= acc saturated to [0x80000000, 0x7FFFFFFF].
  - valid_out=1 for exactly one cycle, busy_out=0, go to IDLE.
- Latency: valid_in sampled at edge T0 gives valid_out high in the cycle after edge T0+N_FILTERS+1.
  - Throughput is one frame per N_FILTERS+2 cycles.
  - A new valid_in is accepted in the same cycle valid_out is high (IDLE is re-entered at that edge).
- sample_out holds its value until the next OUT state.
- Overrun:
  - valid_in while busy_out=1 is ignored and overrun_out pulses one cycle.
  - The frame in progress completes unchanged.
- valid_out deasserts the cycle after it rises, regardless of valid_in.

Optional Feature:
- Macro: BAND_GAIN_EN.
- When defined:
  - Adds input port band_gain_in, unsigned 16 x N_FILTERS, Q1.15 format; 0x8000 is unity.
  - band_gain_in is snapshotted with the frame at valid_in.
  - Each band term becomes ((c*e >>> FRAC_BITS) * gain) >>> 15, computed in 64-bit signed, before accumulation.
  - Latency, throughput and saturation rules are unchanged.
- When undefined: the port does not exist and every band has implicit unity gain.

Test Plan:
- Unity mix: all carrier=0x01000000, all envelope=0x01000000, valid_in pulse -> exactly one valid_out, 9 cycles after the capture edge; sample_out=0x08000000.
- Negative/floor: all carrier=-0x01000000, envelope=0x00800000 -> sample_out=0xFC000000. Then all carrier=-1, envelope=1 -> sample_out=0xFFFFFFF8 (-8, floor per band).
- Saturation: all carrier=0x7FFFFFFF, envelope=0x7FFFFFFF -> sample_out=0x7FFFFFFF. Carrier=0x80000000, envelope=0x7FFFFFFF -> sample_out=0x80000000.
- Overrun: second valid_in 3 cycles after the first with different data -> overrun_out pulses once; one valid_out only, carrying the first frame's result. Back-to-back valid_in in the valid_out cycle -> accepted, and its result appears 10 cycles later.
- Reset mid-frame: assert rst_in 4 cycles into MAC -> all outputs 0 immediately, no valid_out follows. The next frame after release computes correctly.
- BAND_GAIN_EN build: unity-mix frame with band 0 gain 0x4000 and all others 0x8000 -> sample_out=0x07800000; all gains 0 -> sample_out=0.
